// File: rtl/doppler_cfg_pkg.sv
// Shared types, register offsets, reset defaults and length sanitising for the doppler
// configuration sequencer.
package doppler_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam logic [2:0] OFF_SUM_LEN    = 3'd0;
  localparam logic [2:0] OFF_DIVISOR    = 3'd1;
  localparam logic [2:0] OFF_ZC_SUM_LEN = 3'd2;
  localparam logic [2:0] OFF_THRESHOLD  = 3'd3;
  localparam logic [2:0] OFF_OFFSET     = 3'd4;
  localparam logic [2:0] OFF_COMMIT     = 3'd5;

  localparam logic [7:0]  DEF_SUM_LEN    = 8'd1;
  localparam logic [23:0] DEF_DIVISOR    = 24'd1;
  localparam logic [7:0]  DEF_ZC_SUM_LEN = 8'd1;
  localparam logic [31:0] DEF_THRESHOLD  = 32'd0;
  localparam logic [31:0] DEF_OFFSET     = 32'd0;

  function automatic logic [7:0] sanitise_len(input logic [7:0] v, input logic [7:0] max_len);
    if (v == 8'd0) return 8'd1;
    else if (v > max_len) return max_len;
    else return v;
  endfunction

endpackage

// File: rtl/doppler_cfg_sequencer_if.sv
// Settings bus plus the gated AXI-stream handshake between upstream, sequencer and datapath.
interface doppler_cfg_sequencer_if;
   logic        set_stb;
   logic [7:0]  set_addr;
   logic [31:0] set_data;
   logic        s_tvalid;
   logic        s_tlast;
   logic        s_tready;
   logic        m_tvalid;
   logic        m_tready;

   modport master (
      output set_stb, set_addr, set_data, s_tvalid, s_tlast, m_tready,
      input  s_tready, m_tvalid
   );

   modport slave (
      input  set_stb, set_addr, set_data, s_tvalid, s_tlast, m_tready,
      output s_tready, m_tvalid
   );
endinterface

// File: rtl/doppler_cfg_regfile.sv
// Shadow and active configuration banks; the active bank snapshots the sanitised shadow
// bank on commit.
module doppler_cfg_regfile
   import doppler_cfg_pkg::*;
#(
   parameter int unsigned SR_BASE = 129,
   parameter int unsigned MAX_LEN = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        set_stb,
   input  logic [7:0]  set_addr,
   input  logic [31:0] set_data,
   input  logic        commit,
   output logic        commit_wr,
   output logic [7:0]  sum_len,
   output logic [23:0] divisor,
   output logic [7:0]  zc_sum_len,
   output logic [31:0] threshold,
   output logic [31:0] offset
);
   logic [7:0]  rel;
   logic        in_range;
   logic [7:0]  sh_sum_len, sh_zc_sum_len;
   logic [23:0] sh_divisor;
   logic [31:0] sh_threshold, sh_offset;

   // Addresses below SR_BASE wrap to large offsets and fall out of range.
   assign rel       = set_addr - 8'(SR_BASE);
   assign in_range  = set_stb && (rel <= 8'(OFF_COMMIT));
   assign commit_wr = in_range && (rel[2:0] == OFF_COMMIT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_sum_len    <= DEF_SUM_LEN;
         sh_divisor    <= DEF_DIVISOR;
         sh_zc_sum_len <= DEF_ZC_SUM_LEN;
         sh_threshold  <= DEF_THRESHOLD;
         sh_offset     <= DEF_OFFSET;
      end else if (in_range) begin
         case (rel[2:0])
            OFF_SUM_LEN:    sh_sum_len    <= set_data[7:0];
            OFF_DIVISOR:    sh_divisor    <= set_data[23:0];
            OFF_ZC_SUM_LEN: sh_zc_sum_len <= set_data[7:0];
            OFF_THRESHOLD:  sh_threshold  <= set_data;
            OFF_OFFSET:     sh_offset     <= set_data;
            default: ;
         endcase
      end
   end

   // A shadow write landing on the commit edge is not seen by this snapshot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_len    <= DEF_SUM_LEN;
         divisor    <= DEF_DIVISOR;
         zc_sum_len <= DEF_ZC_SUM_LEN;
         threshold  <= DEF_THRESHOLD;
         offset     <= DEF_OFFSET;
      end else if (commit) begin
         sum_len    <= sanitise_len(sh_sum_len, 8'(MAX_LEN));
         divisor    <= (sh_divisor == 24'd0) ? 24'd1 : sh_divisor;
         zc_sum_len <= sanitise_len(sh_zc_sum_len, 8'(MAX_LEN));
         threshold  <= sh_threshold;
         offset     <= sh_offset;
      end
   end
endmodule

// File: rtl/doppler_cfg_sequencer.sv
// Packet-boundary commit sequencer for the doppler tracker configuration.
// Optional registered readback: define DOPPLER_CFG_READBACK_EN.
module doppler_cfg_sequencer
   import doppler_cfg_pkg::*;
#(
   parameter int unsigned SR_BASE      = 129,
   parameter int unsigned MAX_LEN      = 16,
   parameter int unsigned FLUSH_CYCLES = 4
) (
   input  logic                     ce_clk,
   input  logic                     ce_rst,
   doppler_cfg_sequencer_if.slave   bus,
   output logic [7:0]               sum_len,
   output logic [23:0]              divisor,
   output logic [7:0]               zc_sum_len,
   output logic [31:0]              threshold,
   output logic [31:0]              offset,
   output logic                     clear,
   output logic                     cfg_pending,
   output logic [15:0]              commit_count,
   input  logic [2:0]               rb_addr,
   output logic [63:0]              rb_data
);
   localparam int unsigned CntW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   state_e          state_q, state_d;
   logic            armed_q, armed_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [15:0]     count_q, count_d;
   logic            commit, commit_wr, hold, m_tvalid, hs;

   doppler_cfg_regfile #(
      .SR_BASE (SR_BASE),
      .MAX_LEN (MAX_LEN)
   ) u_regfile (
      .clk        (ce_clk),
      .rst        (ce_rst),
      .set_stb    (bus.set_stb),
      .set_addr   (bus.set_addr),
      .set_data   (bus.set_data),
      .commit     (commit),
      .commit_wr  (commit_wr),
      .sum_len    (sum_len),
      .divisor    (divisor),
      .zc_sum_len (zc_sum_len),
      .threshold  (threshold),
      .offset     (offset)
   );

   // Combinational so an armed commit blocks a beat offered in the same cycle.
   assign hold         = (state_q == FLUSH) || ((state_q == IDLE) && armed_q);
   assign m_tvalid     = bus.s_tvalid & ~hold;
   assign bus.m_tvalid = m_tvalid;
   assign bus.s_tready = bus.m_tready & ~hold;
   assign hs           = m_tvalid & bus.m_tready;

   assign clear        = (state_q == FLUSH);
   assign cfg_pending  = armed_q;
   assign commit_count = count_q;

   always_ff @(posedge ce_clk or posedge ce_rst) begin
      if (ce_rst) begin
         state_q <= IDLE;
         armed_q <= 1'b0;
         cnt_q   <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         armed_q <= armed_d;
         cnt_q   <= cnt_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      armed_d = armed_q;
      cnt_d   = cnt_q;
      count_d = count_q;
      commit  = 1'b0;
      case (state_q)
         IDLE: begin
            if (armed_q) begin
               commit  = 1'b1;
               armed_d = 1'b0;
               count_d = count_q + 16'd1;
               cnt_d   = CntW'(FLUSH_CYCLES - 1);
               state_d = FLUSH;
            end else if (hs && !bus.s_tlast) begin
               state_d = BUSY;
            end
         end
         BUSY: if (hs && bus.s_tlast) state_d = IDLE;
         FLUSH: begin
            if (cnt_q == '0) state_d = IDLE;
            else cnt_d = cnt_q - 1'b1;
         end
         default: state_d = IDLE;
      endcase
      // Re-arming wins over the clear so a COMMIT during the commit edge or FLUSH is kept.
      if (commit_wr) armed_d = 1'b1;
   end

`ifdef DOPPLER_CFG_READBACK_EN
   logic [63:0] rb_q, rb_d;

   always_comb begin
      rb_d = '0;
      case (rb_addr)
         3'd0: rb_d = {56'd0, sum_len};
         3'd1: rb_d = {40'd0, divisor};
         3'd2: rb_d = {56'd0, zc_sum_len};
         3'd3: rb_d = {32'd0, threshold};
         3'd4: rb_d = {32'd0, offset};
         3'd5: rb_d = {45'd0, count_q, state_q, armed_q};
         default: rb_d = '0;
      endcase
   end

   always_ff @(posedge ce_clk or posedge ce_rst) begin
      if (ce_rst) rb_q <= '0;
      else        rb_q <= rb_d;
   end

   assign rb_data = rb_q;
`else
   logic unused_rb;
   assign unused_rb = ^rb_addr;
   assign rb_data   = '0;
`endif
endmodule

// File: tb/tb_doppler_cfg_sequencer.sv
// Directed self-checking bench for doppler_cfg_sequencer (default parameters).
module tb_doppler_cfg_sequencer;
   logic        ce_clk = 1'b0;
   logic        ce_rst;
   logic [7:0]  sum_len, zc_sum_len;
   logic [23:0] divisor;
   logic [31:0] threshold, offset;
   logic        clear, cfg_pending;
   logic [15:0] commit_count;
   logic [2:0]  rb_addr;
   logic [63:0] rb_data;
   int          tests_run = 0;
   int          tests_failed = 0;

   localparam logic [7:0] A_SUM = 8'd129, A_DIV = 8'd130, A_ZC = 8'd131;
   localparam logic [7:0] A_THR = 8'd132, A_OFS = 8'd133, A_COMMIT = 8'd134;

   doppler_cfg_sequencer_if bus ();

   doppler_cfg_sequencer dut (
      .ce_clk       (ce_clk),
      .ce_rst       (ce_rst),
      .bus          (bus),
      .sum_len      (sum_len),
      .divisor      (divisor),
      .zc_sum_len   (zc_sum_len),
      .threshold    (threshold),
      .offset       (offset),
      .clear        (clear),
      .cfg_pending  (cfg_pending),
      .commit_count (commit_count),
      .rb_addr      (rb_addr),
      .rb_data      (rb_data)
   );

   always #5 ce_clk = ~ce_clk;

   task automatic write(input logic [7:0] a, input logic [31:0] d);
      @(negedge ce_clk);
      bus.set_stb  = 1'b1;
      bus.set_addr = a;
      bus.set_data = d;
      @(negedge ce_clk);
      bus.set_stb  = 1'b0;
   endtask

   task automatic test_reset();
      ce_rst = 1'b1;
      bus.set_stb = 1'b0; bus.set_addr = '0; bus.set_data = '0;
      bus.s_tvalid = 1'b0; bus.s_tlast = 1'b0; bus.m_tready = 1'b1;
      rb_addr = 3'd0;
      repeat (2) @(negedge ce_clk);
      tests_run++;
      if ({sum_len, divisor, zc_sum_len, threshold, offset} !== {8'd1, 24'd1, 8'd1, 64'd0}) begin
         tests_failed++;
         $display("FAIL reset_active: got %h %h %h %h %h want 1 1 1 0 0",
                  sum_len, divisor, zc_sum_len, threshold, offset);
      end
      tests_run++;
      if ({clear, cfg_pending, commit_count, rb_data} !== 82'd0) begin
         tests_failed++;
         $display("FAIL reset_status: got clear=%b pend=%b cnt=%0d rb=%h want all 0",
                  clear, cfg_pending, commit_count, rb_data);
      end
      ce_rst = 1'b0;
      @(negedge ce_clk);
      tests_run++;
`ifdef DOPPLER_CFG_READBACK_EN
      if (rb_data !== 64'd1) begin
`else
      if (rb_data !== 64'd0) begin
`endif
         tests_failed++;
         $display("FAIL reset_readback: got %h", rb_data);
      end
      bus.s_tvalid = 1'b1; bus.s_tlast = 1'b1; bus.m_tready = 1'b0;
      #1;
      tests_run++;
      if ({bus.m_tvalid, bus.s_tready} !== 2'b10) begin
         tests_failed++;
         $display("FAIL passthrough: got m_tvalid=%b s_tready=%b want 1 0",
                  bus.m_tvalid, bus.s_tready);
      end
   endtask

   // Single-beat packets keep flowing; the commit stalls them for 1 + FLUSH_CYCLES cycles.
   task automatic test_commit_idle();
      int low_rdy = 0, low_vld = 0, clr = 0;
      bus.m_tready = 1'b1;
      write(A_SUM, 32'd8);
      write(A_COMMIT, 32'd0);
      tests_run++;
      if ({cfg_pending, sum_len} !== {1'b1, 8'd1}) begin
         tests_failed++;
         $display("FAIL idle_armed: got pend=%b sum_len=%0d want 1 1", cfg_pending, sum_len);
      end
      for (int i = 0; i < 10; i++) begin
         if (!bus.s_tready) low_rdy++;
         if (!bus.m_tvalid) low_vld++;
         if (clear) clr++;
         if (i == 1) begin
            tests_run++;
            if ({sum_len, commit_count} !== {8'd8, 16'd1}) begin
               tests_failed++;
               $display("FAIL idle_commit: got sum_len=%0d cnt=%0d want 8 1",
                        sum_len, commit_count);
            end
         end
         @(negedge ce_clk);
      end
      tests_run++;
      if ({low_rdy, low_vld, clr} !== {32'd5, 32'd5, 32'd4}) begin
         tests_failed++;
         $display("FAIL idle_stall: got rdy_low=%0d vld_low=%0d clear=%0d want 5 5 4",
                  low_rdy, low_vld, clr);
      end
      bus.s_tvalid = 1'b0; bus.s_tlast = 1'b0;
   endtask

   task automatic test_mid_packet();
      int bad = 0;
      for (int b = 0; b < 16; b++) begin
         @(negedge ce_clk);
         if (b >= 6 && !(cfg_pending && sum_len == 8'd8 && commit_count == 16'd1
                         && bus.s_tready && !clear)) bad++;
         bus.s_tvalid = 1'b1;
         bus.s_tlast  = (b == 15);
         bus.set_stb  = (b == 5);
         bus.set_addr = A_COMMIT;
      end
      @(negedge ce_clk);
      bus.s_tvalid = 1'b0; bus.s_tlast = 1'b0;
      tests_run++;
      if (bad !== 0) begin
         tests_failed++;
         $display("FAIL midpkt_wait: got %0d bad beats want 0", bad);
      end
      tests_run++;
      if ({cfg_pending, bus.s_tready, commit_count} !== {1'b1, 1'b0, 16'd1}) begin
         tests_failed++;
         $display("FAIL midpkt_boundary: got pend=%b rdy=%b cnt=%0d want 1 0 1",
                  cfg_pending, bus.s_tready, commit_count);
      end
      @(negedge ce_clk);
      tests_run++;
      if ({clear, cfg_pending, commit_count} !== {1'b1, 1'b0, 16'd2}) begin
         tests_failed++;
         $display("FAIL midpkt_commit: got clear=%b pend=%b cnt=%0d want 1 0 2",
                  clear, cfg_pending, commit_count);
      end
      repeat (4) @(negedge ce_clk);
   endtask

   task automatic test_sanitise();
      write(A_SUM, 32'd0);
      write(A_DIV, 32'd0);
      write(A_ZC, 32'd40);
      write(A_OFS, 32'hDEADBEEF);
      write(A_COMMIT, 32'd0);
      @(negedge ce_clk);
      tests_run++;
      if ({sum_len, divisor, zc_sum_len, offset, commit_count}
          !== {8'd1, 24'd1, 8'd16, 32'hDEADBEEF, 16'd3}) begin
         tests_failed++;
         $display("FAIL sanitise: got %0d %0d %0d %h cnt=%0d want 1 1 16 deadbeef 3",
                  sum_len, divisor, zc_sum_len, offset, commit_count);
      end
      repeat (4) @(negedge ce_clk);
      write(8'd128, 32'd7);
      write(8'd135, 32'd1);
      tests_run++;
      if ({cfg_pending, clear, sum_len} !== {1'b0, 1'b0, 8'd1}) begin
         tests_failed++;
         $display("FAIL out_of_range: got pend=%b clear=%b sum_len=%0d want 0 0 1",
                  cfg_pending, clear, sum_len);
      end
   endtask

   task automatic test_readback();
      logic [63:0] exp2, exp5;
`ifdef DOPPLER_CFG_READBACK_EN
      exp2 = 64'd16;
      exp5 = 64'd24;  // commit_count 3, state IDLE, not armed
`else
      exp2 = 64'd0;
      exp5 = 64'd0;
`endif
      rb_addr = 3'd2;
      @(negedge ce_clk);
      tests_run++;
      if (rb_data !== exp2) begin
         tests_failed++;
         $display("FAIL readback_zc: got %h want %h", rb_data, exp2);
      end
      rb_addr = 3'd5;
      @(negedge ce_clk);
      tests_run++;
      if (rb_data !== exp5) begin
         tests_failed++;
         $display("FAIL readback_status: got %h want %h", rb_data, exp5);
      end
      rb_addr = 3'd6;
      @(negedge ce_clk);
      tests_run++;
      if (rb_data !== 64'd0) begin
         tests_failed++;
         $display("FAIL readback_unused: got %h want 0", rb_data);
      end
   endtask

   // THRESHOLD lands on the commit edge, COMMIT re-arms during FLUSH.
   task automatic test_back_to_back();
      write(A_COMMIT, 32'd0);
      bus.set_stb = 1'b1; bus.set_addr = A_THR; bus.set_data = 32'h55;
      @(negedge ce_clk);
      tests_run++;
      if ({clear, threshold, commit_count} !== {1'b1, 32'd0, 16'd4}) begin
         tests_failed++;
         $display("FAIL b2b_first: got clear=%b thr=%h cnt=%0d want 1 0 4",
                  clear, threshold, commit_count);
      end
      bus.set_addr = A_COMMIT;
      @(negedge ce_clk);
      bus.set_stb = 1'b0;
      repeat (3) @(negedge ce_clk);
      tests_run++;
      if ({clear, cfg_pending, bus.s_tready} !== {1'b0, 1'b1, 1'b0}) begin
         tests_failed++;
         $display("FAIL b2b_rearmed: got clear=%b pend=%b rdy=%b want 0 1 0",
                  clear, cfg_pending, bus.s_tready);
      end
      @(negedge ce_clk);
      tests_run++;
      if ({clear, threshold, commit_count} !== {1'b1, 32'h55, 16'd5}) begin
         tests_failed++;
         $display("FAIL b2b_second: got clear=%b thr=%h cnt=%0d want 1 55 5",
                  clear, threshold, commit_count);
      end
      repeat (4) @(negedge ce_clk);
   endtask

   task automatic test_reset_flush();
      write(A_SUM, 32'd3);
      write(A_COMMIT, 32'd0);
      @(negedge ce_clk);
      tests_run++;
      if ({clear, sum_len} !== {1'b1, 8'd3}) begin
         tests_failed++;
         $display("FAIL rstflush_pre: got clear=%b sum_len=%0d want 1 3", clear, sum_len);
      end
      #2 ce_rst = 1'b1;
      #1;
      tests_run++;
      if ({clear, cfg_pending, sum_len, threshold, offset, commit_count, bus.s_tready}
          !== {1'b0, 1'b0, 8'd1, 32'd0, 32'd0, 16'd0, 1'b1}) begin
         tests_failed++;
         $display("FAIL rstflush_async: got clear=%b pend=%b sum=%0d thr=%h ofs=%h cnt=%0d rdy=%b",
                  clear, cfg_pending, sum_len, threshold, offset, commit_count, bus.s_tready);
      end
      bus.m_tready = 1'b0;
      #1;
      tests_run++;
      if (bus.s_tready !== 1'b0) begin
         tests_failed++;
         $display("FAIL rstflush_ready: got %b want 0", bus.s_tready);
      end
      @(negedge ce_clk);
      ce_rst = 1'b0;
      bus.m_tready = 1'b1;
      write(A_COMMIT, 32'd0);
      @(negedge ce_clk);
      tests_run++;
      if ({sum_len, commit_count, clear} !== {8'd1, 16'd1, 1'b1}) begin
         tests_failed++;
         $display("FAIL rstflush_shadow: got sum_len=%0d cnt=%0d clear=%b want 1 1 1",
                  sum_len, commit_count, clear);
      end
      repeat (4) @(negedge ce_clk);
   endtask

   initial begin
      test_reset();
      test_commit_idle();
      test_mid_packet();
      test_sanitise();
      test_readback();
      test_back_to_back();
      test_reset_flush();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end
endmodule
